dmem_responder: RTL and testbench

- Data-memory responder: the target end of the load/store interface driven by the core control unit (`addr`, `rd_en`, `wr_en`, `mem_write` in; `mem_read` out).
- Holds a word-organised RAM and services one request at a time with programmable latency.
- Performs byte/half/word lane handling, sign/zero extension, and alignment and range checking.
- Returns a one-cycle response pulse per accepted request.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_lane_unit.sv | 40 ++++
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int LAT_W = 3;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - load/store request and response bundle between core and responder
interface dmem_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] mem_write;
  logic        ready;
  logic [31:0] mem_read;
  logic        resp_valid;
  logic        err;

  modport master (
    output rd_en, wr_en, addr, size, unsigned_ld, mem_write,
    input  ready, mem_read, resp_valid, err
  );

  modport slave (
    input  rd_en, wr_en, addr, size, unsigned_ld, mem_write,
    output ready, mem_read, resp_valid, err
  );

endinterface

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte/half/word lane merge for stores and extraction for loads
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        unsigned_ld,
  output logic [31:0] merged,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8]      = wdata[7:0];
      SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: merged = wdata;
      default: merged = word;
    endcase
  end

  always_comb begin
    ld_data = 32'h0;
    case (size)
      SZ_BYTE: ld_data = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
      SZ_WORD: ld_data = word;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM target with programmable latency, lane handling and fault checks
// Optional DMEM_STATS_EN adds saturating load/store/fault counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] mem [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, wdata_q;
  logic [1:0]       size_q;
  logic             uns_q, rd_q, wr_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             accept, enter_resp, do_write, fault;
  logic [31:0]      req_addr, req_wdata;
  logic [1:0]       req_size;
  logic             req_uns, req_rd, req_wr;
  logic [32:0]      diff;
  logic [IDX_W-1:0] idx;
  logic [31:0]      cur_word, merged, ld_data;

  assign accept = (state_q == ST_IDLE) && (bus.rd_en || bus.wr_en);

  // With zero latency the request is serviced on its accepting edge, so
  // the live inputs feed the datapath while idle.
  assign req_addr  = (state_q == ST_IDLE) ? bus.addr        : addr_q;
  assign req_wdata = (state_q == ST_IDLE) ? bus.mem_write   : wdata_q;
  assign req_size  = (state_q == ST_IDLE) ? bus.size        : size_q;
  assign req_uns   = (state_q == ST_IDLE) ? bus.unsigned_ld : uns_q;
  assign req_rd    = (state_q == ST_IDLE) ? bus.rd_en       : rd_q;
  assign req_wr    = (state_q == ST_IDLE) ? bus.wr_en       : wr_q;

  assign diff = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign idx  = diff[IDX_W+1:2];

  always_comb begin
    fault = 1'b0;
    if (req_rd && req_wr)                                fault = 1'b1;
    if (req_size == SZ_RSVD)                             fault = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])              fault = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)   fault = 1'b1;
    if (diff[32])                                        fault = 1'b1;
    if ({1'b0, diff[31:0]} >= SPAN)                      fault = 1'b1;
  end

  assign cur_word = mem[idx];

  dmem_lane_unit u_lane (
    .word        (cur_word),
    .wdata       (req_wdata),
    .size        (req_size),
    .lane        (req_addr[1:0]),
    .unsigned_ld (req_uns),
    .merged      (merged),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);
  assign do_write   = enter_resp && req_wr && !req_rd && !fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.mem_write;
        size_q  <= bus.size;
        uns_q   <= bus.unsigned_ld;
        rd_q    <= bus.rd_en;
        wr_q    <= bus.wr_en;
      end
      rdata_q <= '0;
      err_q   <= 1'b0;
      if (enter_resp) begin
        err_q <= fault;
        if (req_rd && !req_wr && !fault) rdata_q <= ld_data;
      end
    end
  end

  // Array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= merged;
  end

  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.mem_read   = rdata_q;
  assign bus.err        = err_q;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else if (state_q == ST_RESP) begin
      if (err_q) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (wr_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - four responders (latency 0/1/3/7) driven in lockstep against a byte-level model
// Counter checks are compiled in when DMEM_STATS_EN is defined.
module tb_dmem_responder;

  localparam int          NI    = 4;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] JUNK  = 32'h54;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NI-1:0]       rd_en = '0;
  logic [NI-1:0]       wr_en = '0;
  logic [31:0]         addr = '0;
  logic [31:0]         mem_write = '0;
  logic [1:0]          size = '0;
  logic                unsigned_ld = 1'b0;
  logic [NI-1:0]       ready_v, resp_v, err_v;
  logic [NI-1:0][31:0] rdata_v;
`ifdef DMEM_STATS_EN
  logic [NI-1:0][15:0] rd_cnt, wr_cnt, err_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  int exp_er = 0;

  logic [7:0] mb [NI][DEPTH*4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
    dmem_if u_bus ();
    assign u_bus.rd_en       = rd_en[g];
    assign u_bus.wr_en       = wr_en[g];
    assign u_bus.addr        = addr;
    assign u_bus.size        = size;
    assign u_bus.unsigned_ld = unsigned_ld;
    assign u_bus.mem_write   = mem_write;
    assign ready_v[g]        = u_bus.ready;
    assign resp_v[g]         = u_bus.resp_valid;
    assign err_v[g]          = u_bus.err;
    assign rdata_v[g]        = u_bus.mem_read;

    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (L),
      .BASE_ADDR   (BASE)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (u_bus)
`ifdef DMEM_STATS_EN
      ,
      .rd_count  (rd_cnt[g]),
      .wr_count  (wr_cnt[g]),
      .err_count (err_cnt[g])
`endif
    );
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_req(input int i, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [1:0] sz, input logic u, input logic [31:0] wd,
                           output logic e, output logic [31:0] d);
    int          nb;
    int          off;
    logic [32:0] rel;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    rel = {1'b0, a} - {1'b0, BASE};
    e   = (rd && wr) || (sz == 2'd3) || ((a % 32'(nb)) != 0) || rel[32] || (rel >= 33'(DEPTH * 4));
    d   = '0;
    if (!e) begin
      off = int'(rel[31:0]);
      if (wr) begin
        for (int b = 0; b < nb; b++) mb[i][off + b] = wd[8*b +: 8];
      end else begin
        v = '0;
        for (int b = 0; b < nb; b++) v = v | (32'(mb[i][off + b]) << (8 * b));
        if (!u && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        d = v;
      end
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input bit junk);
    logic        e_exp [NI];
    logic [31:0] d_exp [NI];
    logic        e_got [NI];
    logic [31:0] d_got [NI];
    int          seen  [NI];
    int          at    [NI];
    int          bad   [NI];
    for (int i = 0; i < NI; i++) begin
      model_req(i, rd, wr, a, sz, u, wd, e_exp[i], d_exp[i]);
      seen[i]  = 0;
      at[i]    = -1;
      bad[i]   = 0;
      e_got[i] = 1'b0;
      d_got[i] = '0;
    end
    if (e_exp[0]) exp_er++;
    else if (wr)  exp_wr++;
    else          exp_rd++;

    rd_en       = {NI{rd}};
    wr_en       = {NI{wr}};
    addr        = a;
    size        = sz;
    unsigned_ld = u;
    mem_write   = wd;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (resp_v[i]) begin
          seen[i]++;
          at[i]    = k;
          e_got[i] = err_v[i];
          d_got[i] = rdata_v[i];
        end else if (err_v[i] !== 1'b0 || rdata_v[i] !== 32'h0) begin
          bad[i]++;
        end
        if (ready_v[i] !== (k > lat_of(i))) bad[i]++;
      end
      // A busy responder must ignore anything presented to it.
      rd_en = '0;
      for (int i = 0; i < NI; i++) wr_en[i] = junk && (k < lat_of(i));
      if (junk) begin
        addr      = JUNK;
        size      = 2'd2;
        mem_write = ~wd;
      end
    end
    wr_en = '0;
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("L%0d_resp_count a=%h", lat_of(i), a), 32'(seen[i]), 32'd1);
      check_val($sformatf("L%0d_resp_cycle a=%h", lat_of(i), a), 32'(at[i]), 32'(lat_of(i)));
      check_val($sformatf("L%0d_err a=%h", lat_of(i), a), 32'(e_got[i]), 32'(e_exp[i]));
      check_val($sformatf("L%0d_rdata a=%h", lat_of(i), a), d_got[i], d_exp[i]);
      check_val($sformatf("L%0d_idle_outputs a=%h", lat_of(i), a), 32'(bad[i]), 32'd0);
    end
  endtask

  initial begin
    int spurious;
    int r;
    logic [1:0]  sz;
    logic [31:0] a;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_ready", 32'(ready_v), 32'hF);
    check_val("reset_resp_valid", 32'(resp_v), 32'h0);
    check_val("reset_err", 32'(err_v), 32'h0);
    for (int i = 0; i < NI; i++) check_val($sformatf("reset_rdata_%0d", i), rdata_v[i], 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int w = 0; w < DEPTH; w++) do_req(1'b0, 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, 1'b0);

    do_req(1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0);

    do_req(1'b0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h1122_3344, 1'b0);
    do_req(1'b0, 1'b1, 32'h21, 2'd0, 1'b0, 32'h0000_0080, 1'b0);
    do_req(1'b1, 1'b0, 32'h21, 2'd0, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h21, 2'd0, 1'b1, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0);

    do_req(1'b0, 1'b1, 32'h32, 2'd1, 1'b0, 32'h0000_8001, 1'b0);
    do_req(1'b1, 1'b0, 32'h32, 2'd1, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h32, 2'd1, 1'b1, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 1'b0);

    do_req(1'b1, 1'b0, 32'h13, 2'd2, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'h41, 2'd1, 1'b0, 32'h0000_BEEF, 1'b0);
    do_req(1'b1, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'h20, 2'd3, 1'b0, 32'hFFFF_FFFF, 1'b0);
    do_req(1'b1, 1'b0, 32'(DEPTH * 4), 2'd2, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0);

    do_req(1'b0, 1'b1, 32'h50, 2'd2, 1'b0, 32'h1234_5678, 1'b1);
    do_req(1'b1, 1'b0, JUNK, 2'd2, 1'b0, 32'h0, 1'b0);
    do_req(1'b1, 1'b0, 32'h50, 2'd2, 1'b0, 32'h0, 1'b0);

    // Reset half a cycle after acceptance: only the zero-latency unit has committed.
    rd_en     = '0;
    wr_en     = '1;
    addr      = 32'h40;
    size      = 2'd2;
    mem_write = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    wr_en = '0;
    rst   = 1'b0;
    for (int b = 0; b < 4; b++) mb[0][32'h40 + b] = mem_write[8*b +: 8];
    #1;
    check_val("midop_reset_ready", 32'(ready_v), 32'hF);
    check_val("midop_reset_resp", 32'(resp_v), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    exp_er = 0;
    spurious = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_v != '0) spurious++;
    end
    check_val("midop_no_response", 32'(spurious), 32'd0);
    check_val("midop_ready_after", 32'(ready_v), 32'hF);
    do_req(1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 32'h11F));
      if ($urandom_range(0, 3) != 0) a = a & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
      do_req(r <= 4, (r == 0) || (r > 4), a, sz, 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)));
    end

`ifdef DMEM_STATS_EN
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("L%0d_rd_count", lat_of(i)), 32'(rd_cnt[i]), 32'(exp_rd));
      check_val($sformatf("L%0d_wr_count", lat_of(i)), 32'(wr_cnt[i]), 32'(exp_wr));
      check_val($sformatf("L%0d_err_count", lat_of(i)), 32'(err_cnt[i]), 32'(exp_er));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
